// File: rtl/status_seq.sv
// Status pattern sequencer: walk / blink / hold runs with a per-phase dwell; all outputs registered.
// Optional abort input is compiled in when STATUS_SEQ_ABORT_EN is defined.
module status_seq #(
   parameter int NCH     = 4,
   parameter int DWELL_W = 16,
   parameter int REPS    = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [DWELL_W-1:0] dwell,
`ifdef STATUS_SEQ_ABORT_EN
   input  logic               abort,
`endif
   output logic [NCH-1:0]     status,
   output logic               busy,
   output logic               done
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);
   localparam logic [7:0]    REP_LAST = 8'(REPS);

   localparam logic [1:0] M_WALK  = 2'd0;
   localparam logic [1:0] M_BLINK = 2'd1;
   localparam logic [1:0] M_HOLD  = 2'd2;
   localparam logic [1:0] M_OFF   = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_SET, S_CLR, S_DONE} state_t;

   state_t               state, state_n;
   logic [1:0]           mode_q, mode_n;
   logic [DWELL_W-1:0]   dwell_q, dwell_n;
   logic [DWELL_W-1:0]   cnt, cnt_n;
   logic [IW-1:0]        idx, idx_n;
   logic [7:0]           rep, rep_n;
   logic [7:0]           rep_inc;
   logic [NCH-1:0]       status_n;
   logic                 busy_n;
   logic                 done_n;
   logic                 abort_req;

   // Counter holds (phase length - 1); a zero dwell behaves as a one-clock phase.
   function automatic logic [DWELL_W-1:0] reload(input logic [DWELL_W-1:0] d);
      return (d == '0) ? '0 : d - DWELL_W'(1);
   endfunction

`ifdef STATUS_SEQ_ABORT_EN
   assign abort_req = abort && (state != S_IDLE);
`else
   assign abort_req = 1'b0;
`endif

   assign rep_inc = rep + 8'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         mode_q  <= M_WALK;
         dwell_q <= '0;
         cnt     <= '0;
         idx     <= '0;
         rep     <= '0;
         status  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         mode_q  <= mode_n;
         dwell_q <= dwell_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         rep     <= rep_n;
         status  <= status_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      mode_n  = mode_q;
      dwell_n = dwell_q;
      cnt_n   = cnt;
      idx_n   = idx;
      rep_n   = rep;
      if (abort_req) begin
         state_n = S_IDLE;
         cnt_n   = '0;
         idx_n   = '0;
         rep_n   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && mode != M_OFF) begin
                  state_n = S_SET;
                  mode_n  = mode;
                  dwell_n = dwell;
                  cnt_n   = reload(dwell);
                  idx_n   = '0;
                  rep_n   = '0;
               end
            end
            S_SET: begin
               if (cnt != '0) begin
                  cnt_n = cnt - DWELL_W'(1);
               end else if (mode_q == M_HOLD) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_CLR;
                  cnt_n   = reload(dwell_q);
               end
            end
            S_CLR: begin
               if (cnt != '0) begin
                  cnt_n = cnt - DWELL_W'(1);
               end else begin
                  state_n = S_SET;
                  cnt_n   = reload(dwell_q);
                  if (mode_q == M_WALK && idx != IDX_LAST) begin
                     idx_n = idx + IW'(1);
                  end else begin
                     idx_n = '0;
                     rep_n = rep_inc;
                     if (rep_inc == REP_LAST) begin
                        state_n = S_DONE;
                        cnt_n   = '0;
                     end
                  end
               end
            end
            default: begin
               state_n = S_IDLE;
               cnt_n   = '0;
               idx_n   = '0;
               rep_n   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so the registers line up with the state they describe.
   always_comb begin
      status_n = '0;
      busy_n   = (state_n == S_SET) || (state_n == S_CLR);
      done_n   = (state_n == S_DONE);
      if (state_n == S_SET) begin
         if (mode_n == M_WALK) status_n = {{(NCH-1){1'b0}}, 1'b1} << idx_n;
         else                  status_n = '1;
      end
   end

endmodule

// File: tb/tb_status_seq.sv
// Directed bench for status_seq with NCH=4, REPS=2; cycle n is the clock period after the n-th sampling edge.
module tb_status_seq;

   localparam int NCH = 4;
   localparam int DW  = 16;

   logic           clk = 1'b0;
   logic           reset_n = 1'b1;
   logic           start = 1'b0;
   logic [1:0]     mode = 2'd0;
   logic [DW-1:0]  dwell = '0;
`ifdef STATUS_SEQ_ABORT_EN
   logic           abort = 1'b0;
`endif
   logic [NCH-1:0] status;
   logic           busy;
   logic           done;

   int checks = 0;
   int failures = 0;

   status_seq #(.NCH(NCH), .DWELL_W(DW), .REPS(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .mode    (mode),
      .dwell   (dwell),
`ifdef STATUS_SEQ_ABORT_EN
      .abort   (abort),
`endif
      .status  (status),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives start for one clock; returns at the start of cycle 1.
   task automatic launch(input logic [1:0] m, input logic [DW-1:0] d);
      start = 1'b1;
      mode  = m;
      dwell = d;
      tick();
      start = 1'b0;
   endtask

   // Expected walk pattern for NCH=4: even phases light bit (phase/2), odd phases are dark.
   function automatic logic [NCH-1:0] walk_exp(input int c, input int d);
      int p;
      logic [NCH-1:0] one;
      one = 4'b0001;
      p = ((c - 1) / d) % 8;
      return (p % 2 == 0) ? (one << (p / 2)) : 4'b0000;
   endfunction

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (status !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: status=%b busy=%b done=%b, want 0000/0/0", status, busy, done);
      end
      tick();
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || status !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle cycle %0d: busy=%b status=%b, want 0/0000", c, busy, status);
         end
      end
   endtask

   task automatic test_walk();
      logic [NCH-1:0] exp_s;
      launch(2'd0, 16'd3);
      for (int c = 1; c <= 50; c++) begin
         exp_s = (c <= 48) ? walk_exp(c, 3) : 4'b0000;
         checks++;
         if (status !== exp_s) begin
            failures++;
            $display("FAIL walk_status cycle %0d: got %b want %b", c, status, exp_s);
         end
         checks++;
         if (busy !== (c <= 48)) begin
            failures++;
            $display("FAIL walk_busy cycle %0d: got %b want %b", c, busy, (c <= 48));
         end
         checks++;
         if (done !== (c == 49)) begin
            failures++;
            $display("FAIL walk_done cycle %0d: got %b want %b", c, done, (c == 49));
         end
         tick();
      end
   endtask

   task automatic test_blink();
      logic [NCH-1:0] exp_s [1:10];
      exp_s = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
      launch(2'd1, 16'd2);
      for (int c = 1; c <= 10; c++) begin
         if (c == 4) begin
            mode  = 2'd0;
            dwell = 16'd7;
         end
         checks++;
         if (status !== exp_s[c]) begin
            failures++;
            $display("FAIL blink_status cycle %0d: got %b want %b", c, status, exp_s[c]);
         end
         checks++;
         if (busy !== (c <= 8) || done !== (c == 9)) begin
            failures++;
            $display("FAIL blink_busy_done cycle %0d: got %b%b want %b%b", c, busy, done, (c <= 8), (c == 9));
         end
         tick();
      end
   endtask

   task automatic test_hold_off();
      launch(2'd2, 16'd5);
      for (int c = 1; c <= 7; c++) begin
         checks++;
         if (status !== ((c <= 5) ? 4'hF : 4'h0)) begin
            failures++;
            $display("FAIL hold_status cycle %0d: got %b want %b", c, status, ((c <= 5) ? 4'hF : 4'h0));
         end
         checks++;
         if (busy !== (c <= 5) || done !== (c == 6)) begin
            failures++;
            $display("FAIL hold_busy_done cycle %0d: got %b%b want %b%b", c, busy, done, (c <= 5), (c == 6));
         end
         tick();
      end
      launch(2'd3, 16'd5);
      for (int c = 1; c <= 5; c++) begin
         checks++;
         if (busy !== 1'b0 || status !== 4'h0 || done !== 1'b0) begin
            failures++;
            $display("FAIL off_mode cycle %0d: busy=%b status=%b done=%b, want 0/0000/0", c, busy, status, done);
         end
         tick();
      end
   endtask

   task automatic test_dwell_zero();
      logic [NCH-1:0] exp_s;
      launch(2'd0, 16'd0);
      for (int c = 1; c <= 18; c++) begin
         start = (c == 5);
         exp_s = (c <= 16) ? walk_exp(c, 1) : 4'b0000;
         checks++;
         if (status !== exp_s) begin
            failures++;
            $display("FAIL dwell0_status cycle %0d: got %b want %b", c, status, exp_s);
         end
         checks++;
         if (busy !== (c <= 16) || done !== (c == 17)) begin
            failures++;
            $display("FAIL dwell0_busy_done cycle %0d: got %b%b want %b%b", c, busy, done, (c <= 16), (c == 17));
         end
         tick();
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      launch(2'd0, 16'd4);
      for (int c = 1; c < 10; c++) tick();
      checks++;
      if (status !== 4'b0010 || busy !== 1'b1) begin
         failures++;
         $display("FAIL midrun_before_reset: status=%b busy=%b want 0010/1", status, busy);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (status !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL midrun_async_reset: status=%b busy=%b done=%b want 0000/0/0", status, busy, done);
      end
      tick();
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || status !== 4'b0000) begin
            failures++;
            $display("FAIL midrun_no_autorun: busy=%b status=%b want 0/0000", busy, status);
         end
      end
      launch(2'd0, 16'd4);
      checks++;
      if (status !== 4'b0001 || busy !== 1'b1) begin
         failures++;
         $display("FAIL midrun_restart: status=%b busy=%b want 0001/1", status, busy);
      end
      for (int c = 1; c <= 66; c++) tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL midrun_finish: busy=%b want 0", busy);
      end
   endtask

`ifdef STATUS_SEQ_ABORT_EN
   task automatic test_abort();
      logic [NCH-1:0] exp_s [1:4];
      exp_s = '{4'hF, 4'hF, 4'hF, 4'h0};
      launch(2'd1, 16'd3);
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (status !== exp_s[c]) begin
            failures++;
            $display("FAIL abort_pre cycle %0d: got %b want %b", c, status, exp_s[c]);
         end
         if (c == 4) abort = 1'b1;
         tick();
      end
      abort = 1'b0;
      checks++;
      if (status !== 4'h0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_cycle5: status=%b busy=%b want 0000/0", status, busy);
      end
      for (int c = 5; c <= 12; c++) begin
         checks++;
         if (done !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done cycle %0d: got %b want 0", c, done);
         end
         tick();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_walk();
      test_blink();
      test_hold_off();
      test_dwell_zero();
      test_reset_mid_run();
`ifdef STATUS_SEQ_ABORT_EN
      test_abort();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
